// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV64 subset control path.
// Holds the main FSM state enum, opcode constants, ALUOp encodings,
// the packed datapath-control bundle and the Funct selection helper.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StExecR,
    StExecI,
    StAddr,
    StMemRd,
    StMemWr,
    StWbAlu,
    StWbMem,
    StBranch,
    StTrap
  } state_e;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BEQ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       pc_src;
    logic [1:0] alu_op;
    logic       busy;
  } ctrl_t;

  // funct7[5] only distinguishes add/sub for R-type; I-type shares funct3 with
  // immediate bits in that position, so it is masked there.
  function automatic logic [3:0] funct_sel(input logic [6:0] op, input logic f7b5,
                                           input logic [2:0] f3);
    return (op == OP_R) ? {f7b5, f3} : {1'b0, f3};
  endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Bus between the main control FSM and the datapath/memory side.
// master: control FSM (drives enables, ALUOp/Funct, status).
// slave : datapath/memory (drives instr, mem_ready, zero).
interface multicycle_main_control_if #(
  parameter int unsigned RET_CNT_W = 32
) ();
  logic [31:0]          instr;
  logic                 mem_ready;
  logic                 zero;
  logic [1:0]           ALUOp;
  logic [3:0]           Funct;
  logic                 ir_write;
  logic                 pc_write;
  logic                 mem_read;
  logic                 mem_write;
  logic                 reg_write;
  logic                 mem_to_reg;
  logic                 alu_src;
  logic                 pc_src;
  logic                 busy;
  logic [RET_CNT_W-1:0] instr_retired;
  logic                 illegal;

  modport master (
    input  instr, mem_ready, zero,
    output ALUOp, Funct, ir_write, pc_write, mem_read, mem_write, reg_write,
           mem_to_reg, alu_src, pc_src, busy, instr_retired, illegal
  );

  modport slave (
    output instr, mem_ready, zero,
    input  ALUOp, Funct, ir_write, pc_write, mem_read, mem_write, reg_write,
           mem_to_reg, alu_src, pc_src, busy, instr_retired, illegal
  );
endinterface

// File: rtl/main_ctrl_outdec.sv
// Combinational state-to-control decode for the main FSM.
// Ports: i_state (FSM state), i_active (0 while reset is asserted),
//        i_mem_ready / i_zero (gate FETCH writes and branch PC write),
//        i_funct (Funct from captured fields), o_ctrl (enables bundle), o_funct.
module main_ctrl_outdec
  import rv_ctrl_pkg::*;
(
  input  state_e     i_state,
  input  logic       i_active,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  input  logic [3:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic [3:0] o_funct
);

  always_comb begin
    o_ctrl  = '0;
    o_funct = i_funct;
    unique case (i_state)
      StFetch: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.ir_write = i_mem_ready;
        o_ctrl.pc_write = i_mem_ready;
        o_funct         = '0;
      end
      StExecR: o_ctrl.alu_op = ALUOP_R;
      StExecI: o_ctrl.alu_src = 1'b1;
      StAddr:  o_ctrl.alu_src = 1'b1;
      StMemRd: o_ctrl.mem_read = 1'b1;
      StMemWr: o_ctrl.mem_write = 1'b1;
      StWbAlu: o_ctrl.reg_write = 1'b1;
      StWbMem: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      StBranch: begin
        o_ctrl.alu_op   = ALUOP_BEQ;
        o_ctrl.pc_src   = 1'b1;
        o_ctrl.pc_write = i_zero;
      end
      default: ;
    endcase
    o_ctrl.busy = (i_state != StFetch);
    // Asynchronous reset must silence every enable immediately, even FETCH's read.
    if (!i_active) begin
      o_ctrl  = '0;
      o_funct = '0;
    end
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle RV64 subset core
// (ld, sd, add, sub, and, or, addi, slli, beq).
// Ports: clk, reset (async, active-low), bus (multicycle_main_control_if.master:
//        instr/mem_ready/zero in; ALUOp/Funct, datapath enables, busy,
//        instr_retired, illegal out).
// Optional: ILLEGAL_TRAP_EN -- illegal opcodes lock the FSM in TRAP with a sticky
//           illegal flag; otherwise they are dropped as an uncounted NOP.
module multicycle_main_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned RET_CNT_W = 32
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_main_control_if.master bus
);

  state_e               r_state;
  logic [6:0]           r_opcode;
  logic [2:0]           r_funct3;
  logic                 r_f7b5;
  logic [RET_CNT_W-1:0] r_ret_cnt;
  ctrl_t                w_ctrl;
  logic [3:0]           w_funct;
`ifdef ILLEGAL_TRAP_EN
  logic                 r_illegal;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StFetch;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_f7b5    <= 1'b0;
      r_ret_cnt <= '0;
`ifdef ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StFetch: begin
          if (bus.mem_ready) begin
            r_opcode <= bus.instr[6:0];
            r_funct3 <= bus.instr[14:12];
            r_f7b5   <= bus.instr[30];
            r_state  <= StDecode;
          end
        end
        StDecode: begin
          unique case (r_opcode)
            OP_R:         r_state <= StExecR;
            OP_I:         r_state <= StExecI;
            OP_LD, OP_SD: r_state <= StAddr;
            OP_BR:        r_state <= StBranch;
            default: begin
`ifdef ILLEGAL_TRAP_EN
              r_state   <= StTrap;
              r_illegal <= 1'b1;
`else
              r_state   <= StFetch;
`endif
            end
          endcase
        end
        StExecR, StExecI: r_state <= StWbAlu;
        StAddr: r_state <= (r_opcode == OP_SD) ? StMemWr : StMemRd;
        StMemRd: begin
          if (bus.mem_ready) r_state <= StWbMem;
        end
        StMemWr: begin
          if (bus.mem_ready) begin
            r_state   <= StFetch;
            r_ret_cnt <= r_ret_cnt + 1'b1;
          end
        end
        StWbAlu, StWbMem, StBranch: begin
          r_state   <= StFetch;
          r_ret_cnt <= r_ret_cnt + 1'b1;
        end
        StTrap: r_state <= StTrap;
        default: r_state <= StFetch;
      endcase
    end
  end

  main_ctrl_outdec u_outdec (
    .i_state    (r_state),
    .i_active   (reset),
    .i_mem_ready(bus.mem_ready),
    .i_zero     (bus.zero),
    .i_funct    (funct_sel(r_opcode, r_f7b5, r_funct3)),
    .o_ctrl     (w_ctrl),
    .o_funct    (w_funct)
  );

  assign bus.ALUOp         = w_ctrl.alu_op;
  assign bus.Funct         = w_funct;
  assign bus.ir_write      = w_ctrl.ir_write;
  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.mem_read      = w_ctrl.mem_read;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign bus.alu_src       = w_ctrl.alu_src;
  assign bus.pc_src        = w_ctrl.pc_src;
  assign bus.busy          = w_ctrl.busy;
  assign bus.instr_retired = r_ret_cnt;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal       = r_illegal;
`else
  assign bus.illegal       = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control. A narrow retire counter is
// used so that running the vector table twice exercises counter wrap.
module tb_multicycle_main_control;

  localparam int unsigned CNT_W = 3;
  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  typedef enum int {KR, KI, KLD, KSD, KBR, KILL} kind_e;
  typedef struct {
    logic [31:0] instr;
    kind_e       kind;
    logic        zero;
    logic [3:0]  funct;
    int          fs;  // FETCH stall cycles
    int          ms;  // MEM_RD / MEM_WR stall cycles
  } vec_t;
  // en bits: ir_write, pc_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src, pc_src
  typedef struct packed {
    logic [7:0] en;
    logic [1:0] aluop;
    logic [3:0] funct;
    logic       busy;
  } obs_t;
  typedef struct {
    logic        mr;
    logic [31:0] instr;
  } stim_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_main_control_if #(.RET_CNT_W(CNT_W)) bus ();

  multicycle_main_control #(.RET_CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  obs_t             exp_q[$];
  stim_t            stim_q[$];
  vec_t             vecs[$];
  int               total = 0;
  int               bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic obs_t mk(input logic [7:0] en, input logic [1:0] a, input logic [3:0] f,
                              input logic b);
    obs_t o;
    o.en = en; o.aluop = a; o.funct = f; o.busy = b;
    return o;
  endfunction

  function automatic obs_t sample();
    return {bus.ir_write, bus.pc_write, bus.mem_read, bus.mem_write, bus.reg_write,
            bus.mem_to_reg, bus.alu_src, bus.pc_src, bus.ALUOp, bus.Funct, bus.busy};
  endfunction

  task automatic check_obs(input string name, input obs_t e);
    obs_t g;
    g = sample();
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got en=%b aluop=%b funct=%b busy=%b, want en=%b aluop=%b funct=%b busy=%b",
               name, g.en, g.aluop, g.funct, g.busy, e.en, e.aluop, e.funct, e.busy);
    end
  endtask

  task automatic check_bit(input string name, input logic g, input logic e);
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, g, e);
    end
  endtask

  task automatic check_cnt(input string name);
    total++;
    if (bus.instr_retired !== exp_cnt) begin
      bad++;
      $display("FAIL %s retired: got %0d want %0d", name, bus.instr_retired, exp_cnt);
    end
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic mr, input logic [31:0] ins, input obs_t e);
    stim_t s;
    s.mr = mr; s.instr = ins;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic build(input vec_t v);
    for (int i = 0; i < v.fs; i++) push(1'b0, v.instr, mk(8'b0010_0000, 2'b00, 4'h0, 1'b0));
    push(1'b1, v.instr, mk(8'b1110_0000, 2'b00, 4'h0, 1'b0));
    push(rnd(), JUNK, mk(8'b0000_0000, 2'b00, v.funct, 1'b1));
    case (v.kind)
      KR: begin
        push(rnd(), JUNK, mk(8'b0000_0000, 2'b10, v.funct, 1'b1));
        push(rnd(), JUNK, mk(8'b0000_1000, 2'b00, v.funct, 1'b1));
      end
      KI: begin
        push(rnd(), JUNK, mk(8'b0000_0010, 2'b00, v.funct, 1'b1));
        push(rnd(), JUNK, mk(8'b0000_1000, 2'b00, v.funct, 1'b1));
      end
      KLD: begin
        push(rnd(), JUNK, mk(8'b0000_0010, 2'b00, v.funct, 1'b1));
        for (int i = 0; i < v.ms; i++) push(1'b0, JUNK, mk(8'b0010_0000, 2'b00, v.funct, 1'b1));
        push(1'b1, JUNK, mk(8'b0010_0000, 2'b00, v.funct, 1'b1));
        push(rnd(), JUNK, mk(8'b0000_1100, 2'b00, v.funct, 1'b1));
      end
      KSD: begin
        push(rnd(), JUNK, mk(8'b0000_0010, 2'b00, v.funct, 1'b1));
        for (int i = 0; i < v.ms; i++) push(1'b0, JUNK, mk(8'b0001_0000, 2'b00, v.funct, 1'b1));
        push(1'b1, JUNK, mk(8'b0001_0000, 2'b00, v.funct, 1'b1));
      end
      KBR: push(rnd(), JUNK, mk({1'b0, v.zero, 5'b0, 1'b1}, 2'b01, v.funct, 1'b1));
      default: ;
    endcase
  endtask

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_trace(input string name);
    stim_t s;
    obs_t  e;
    int    cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      bus.mem_ready = s.mr;
      bus.instr     = s.instr;
      @(negedge clk);
      check_obs($sformatf("%s cyc%0d", name, cyc), e);
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    bus.zero = v.zero;
    build(v);
    run_trace(name);
    if (v.kind != KILL) exp_cnt = exp_cnt + 1'b1;
    check_cnt(name);
    check_bit({name, " illegal"}, bus.illegal, 1'b0);
  endtask

  function automatic vec_t mkv(input logic [31:0] ins, input kind_e k, input logic z,
                               input logic [3:0] f, input int fs, input int ms);
    vec_t v;
    v.instr = ins; v.kind = k; v.zero = z; v.funct = f; v.fs = fs; v.ms = ms;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back(mkv(32'h00A302B3, KR,  1'b0, 4'b0000, 0, 0)); // add
    vecs.push_back(mkv(32'h40A302B3, KR,  1'b0, 4'b1000, 0, 0)); // sub
    vecs.push_back(mkv(32'h00A372B3, KR,  1'b0, 4'b0111, 0, 0)); // and
    vecs.push_back(mkv(32'h00A362B3, KR,  1'b1, 4'b0110, 0, 0)); // or
    vecs.push_back(mkv(32'h00331293, KI,  1'b0, 4'b0001, 0, 0)); // slli
    vecs.push_back(mkv(32'h00330293, KI,  1'b0, 4'b0000, 1, 0)); // addi, fetch stall
    vecs.push_back(mkv(32'h00833283, KLD, 1'b0, 4'b0011, 0, 2)); // ld, 2-cycle stall
    vecs.push_back(mkv(32'h00833283, KLD, 1'b0, 4'b0011, 1, 0)); // ld, fetch stall
    vecs.push_back(mkv(32'h00533423, KSD, 1'b0, 4'b0011, 0, 1)); // sd, 1-cycle stall
    vecs.push_back(mkv(32'h00628463, KBR, 1'b1, 4'b0000, 0, 0)); // beq taken
    vecs.push_back(mkv(32'h00628463, KBR, 1'b0, 4'b0000, 0, 0)); // beq not taken
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back(mkv(32'h0000007F, KILL, 1'b0, 4'b0000, 0, 0)); // illegal as NOP
`endif

    bus.instr = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    #12;
    check_obs("reset outputs", mk(8'h00, 2'b00, 4'h0, 1'b0));
    check_cnt("reset");
    check_bit("reset illegal", bus.illegal, 1'b0);
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < vecs.size(); i++)
        run_vec(vecs[i], $sformatf("vec%0d.%0d", rep, i));

    // Reset while MEM_WR is waiting on memory: write enable must drop at once.
    bus.zero = 1'b0;
    push(1'b1, 32'h00533423, mk(8'b1110_0000, 2'b00, 4'h0, 1'b0));
    push(rnd(), JUNK, mk(8'b0000_0000, 2'b00, 4'b0011, 1'b1));
    push(rnd(), JUNK, mk(8'b0000_0010, 2'b00, 4'b0011, 1'b1));
    push(1'b0, JUNK, mk(8'b0001_0000, 2'b00, 4'b0011, 1'b1));
    run_trace("sd_abort");
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check_obs("sd_abort pre", mk(8'b0001_0000, 2'b00, 4'b0011, 1'b1));
    #1 reset = 1'b0;
    #1;
    check_obs("sd_abort async", mk(8'h00, 2'b00, 4'h0, 1'b0));
    exp_cnt = '0;
    check_cnt("sd_abort");
    @(posedge clk);
    #2 reset = 1'b1;
    run_vec(vecs[0], "after_abort add");

`ifdef ILLEGAL_TRAP_EN
    bus.zero = 1'b0;
    push(1'b1, 32'h0000007F, mk(8'b1110_0000, 2'b00, 4'h0, 1'b0));
    push(rnd(), JUNK, mk(8'b0000_0000, 2'b00, 4'h0, 1'b1));
    run_trace("illegal");
    for (int i = 0; i < 100; i++) begin
      bus.mem_ready = rnd();
      @(negedge clk);
      check_obs($sformatf("trap cyc%0d", i), mk(8'h00, 2'b00, 4'h0, 1'b1));
      check_bit($sformatf("trap illegal cyc%0d", i), bus.illegal, 1'b1);
      @(posedge clk);
      #1;
    end
    check_cnt("trap");
    reset = 1'b0;
    #1;
    check_bit("trap cleared", bus.illegal, 1'b0);
    exp_cnt = '0;
    check_cnt("trap reset");
    @(posedge clk);
    #2 reset = 1'b1;
    run_vec(vecs[0], "after_trap add");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
